// File: rtl/cam_pkg.sv
// Shared opcode and FSM definitions for the sequenced CAM subarray.
package cam_pkg;

    typedef enum logic [2:0] {
        OP_WRITE      = 3'b000,
        OP_UPDATE     = 3'b001,
        OP_SRCH1      = 3'b010,
        OP_SRCH2      = 3'b011,
        OP_SRCH1_ACC  = 3'b100,
        OP_SRCH2_ACC  = 3'b101,
        OP_UPDATE_ACC = 3'b110,
        OP_CLR_ACC    = 3'b111
    } cam_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } cam_state_e;

    // True for every opcode that produces a response.
    function automatic logic is_search(input cam_op_e op);
        return (op == OP_SRCH1) || (op == OP_SRCH2) ||
               (op == OP_SRCH1_ACC) || (op == OP_SRCH2_ACC);
    endfunction

    // True for opcodes that compare against both row_a and row_b.
    function automatic logic is_two_row(input cam_op_e op);
        return (op == OP_SRCH2) || (op == OP_SRCH2_ACC);
    endfunction

    // True for opcodes that take the accumulator as the column mask.
    function automatic logic uses_acc(input cam_op_e op);
        return (op == OP_SRCH1_ACC) || (op == OP_SRCH2_ACC) || (op == OP_UPDATE_ACC);
    endfunction

endpackage

// File: rtl/cam_popcount.sv
// Combinational population count of a match vector.
module cam_popcount #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits_i,
    output logic [CW-1:0] count_o
);

    // Sum of all set bits; flattens into an adder tree.
    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/cam_subarray_seq.sv
// ROWS x COLS CAM subarray with valid/ready command and response ports.
module cam_subarray_seq
    import cam_pkg::*;
#(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 36,
    parameter int unsigned AW   = $clog2(ROWS),
    parameter int unsigned CW   = $clog2(COLS + 1)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [AW-1:0]   cmd_row_a,
    input  logic [AW-1:0]   cmd_row_b,
    input  logic [1:0]      cmd_key,
    input  logic [COLS-1:0] cmd_data,
    input  logic [COLS-1:0] cmd_mask,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [COLS-1:0] rsp_tag,
    output logic [CW-1:0]   rsp_count,
    output logic            rsp_err,
    output logic [COLS-1:0] acc_tag
);

    localparam logic [AW:0] ROWS_W = (AW + 1)'(ROWS);

    logic [COLS-1:0] mem [ROWS];

    cam_state_e      state_q, state_d;
    cam_op_e         op_q, op_d;
    logic [AW-1:0]   row_a_q, row_a_d;
    logic [AW-1:0]   row_b_q, row_b_d;
    logic [1:0]      key_q, key_d;
    logic [COLS-1:0] data_q, data_d;
    logic [COLS-1:0] mask_q, mask_d;
    logic [COLS-1:0] rsp_tag_q, rsp_tag_d;
    logic [CW-1:0]   rsp_count_q, rsp_count_d;
    logic            rsp_err_q, rsp_err_d;
    logic [COLS-1:0] acc_q, acc_d;

    logic            row_a_ok, row_b_ok, rows_ok, two_row;
    logic [AW-1:0]   idx_a, idx_b;
    logic [COLS-1:0] rd_a, rd_b, m_a, m_b, sel_mask, tag_nx;
    logic [COLS-1:0] upd_mask, wr_row;
    logic [CW-1:0]   count_nx;
    logic            mem_we;

    // Row read, column match and next tag for the operation held in the operand registers.
    always_comb begin
        two_row  = is_two_row(op_q);
        row_a_ok = ({1'b0, row_a_q} < ROWS_W);
        row_b_ok = ({1'b0, row_b_q} < ROWS_W);
        rows_ok  = row_a_ok && (!two_row || row_b_ok);
        // Out-of-range addresses are steered to row 0; their results are discarded.
        idx_a    = row_a_ok ? row_a_q : '0;
        idx_b    = row_b_ok ? row_b_q : '0;
        rd_a     = mem[idx_a];
        rd_b     = mem[idx_b];
        m_a      = key_q[0] ? rd_a : ~rd_a;
        m_b      = two_row ? (key_q[1] ? rd_b : ~rd_b) : '1;
        sel_mask = uses_acc(op_q) ? acc_q : mask_q;
        tag_nx   = sel_mask & m_a & m_b;
        upd_mask = (op_q == OP_WRITE) ? '1 : sel_mask;
        wr_row   = (rd_a & ~upd_mask) | (data_q & upd_mask);
        mem_we   = !RST && (state_q == ST_EXEC) && row_a_ok &&
                   ((op_q == OP_WRITE) || (op_q == OP_UPDATE) || (op_q == OP_UPDATE_ACC));
    end

    cam_popcount #(
        .W  (COLS),
        .CW (CW)
    ) u_popcount (
        .bits_i  (tag_nx),
        .count_o (count_nx)
    );

    // Array storage; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx_a] <= wr_row;
        end
    end

    // FSM next state, handshake outputs and register next values.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        row_a_d     = row_a_q;
        row_b_d     = row_b_q;
        key_d       = key_q;
        data_d      = data_q;
        mask_d      = mask_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_count_d = rsp_count_q;
        rsp_err_d   = rsp_err_q;
        acc_d       = acc_q;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cam_op_e'(cmd_op);
                    row_a_d = cmd_row_a;
                    row_b_d = cmd_row_b;
                    key_d   = cmd_key;
                    data_d  = cmd_data;
                    mask_d  = cmd_mask;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_search(op_q)) begin
                    if (rows_ok) begin
                        rsp_tag_d   = tag_nx;
                        rsp_count_d = count_nx;
                        rsp_err_d   = 1'b0;
                        acc_d       = tag_nx;
                    end else begin
                        rsp_tag_d   = '0;
                        rsp_count_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    if (op_q == OP_CLR_ACC) begin
                        acc_d = '1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            row_a_q     <= '0;
            row_b_q     <= '0;
            key_q       <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            rsp_tag_q   <= '0;
            rsp_count_q <= '0;
            rsp_err_q   <= 1'b0;
            acc_q       <= '1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            row_a_q     <= row_a_d;
            row_b_q     <= row_b_d;
            key_q       <= key_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_count_q <= rsp_count_d;
            rsp_err_q   <= rsp_err_d;
            acc_q       <= acc_d;
        end
    end

    assign rsp_tag   = rsp_tag_q;
    assign rsp_count = rsp_count_q;
    assign rsp_err   = rsp_err_q;
    assign acc_tag   = acc_q;

endmodule

// File: tb/tb_cam_subarray_seq.sv
// Randomized self-checking bench for cam_subarray_seq with a behavioural array model.
module tb_cam_subarray_seq;

    localparam int COLS = 32;
    localparam int ROWS = 36;
    localparam int AW   = 6;
    localparam int CW   = 6;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = '0;
    logic [AW-1:0]   cmd_row_a = '0;
    logic [AW-1:0]   cmd_row_b = '0;
    logic [1:0]      cmd_key = '0;
    logic [COLS-1:0] cmd_data = '0;
    logic [COLS-1:0] cmd_mask = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [COLS-1:0] rsp_tag;
    logic [CW-1:0]   rsp_count;
    logic            rsp_err;
    logic [COLS-1:0] acc_tag;

    int total = 0;
    int bad   = 0;

    logic [COLS-1:0] ref_mem [ROWS];
    logic [COLS-1:0] ref_acc = '1;

    cam_subarray_seq #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row_a (cmd_row_a),
        .cmd_row_b (cmd_row_b),
        .cmd_key   (cmd_key),
        .cmd_data  (cmd_data),
        .cmd_mask  (cmd_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tag   (rsp_tag),
        .rsp_count (rsp_count),
        .rsp_err   (rsp_err),
        .acc_tag   (acc_tag)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model of a non-search command: applied when the DUT commits it.
    task automatic model_nonsearch(input int op, input int a, input logic [31:0] data,
                                   input logic [31:0] mask);
        logic [31:0] m;
        if (op == 7) begin
            ref_acc = '1;
        end else if (a < ROWS) begin
            m = (op == 0) ? 32'hFFFF_FFFF : (op == 6) ? ref_acc : mask;
            for (int j = 0; j < COLS; j++)
                if (m[j]) ref_mem[a][j] = data[j];
        end
    endtask

    // Model of a search: expected tag/count/err, updating the accumulator.
    task automatic model_search(input int op, input int a, input int b, input logic [1:0] key,
                                input logic [31:0] mask, output logic [31:0] etag,
                                output int ecnt, output logic eerr);
        bit two;
        bit sel, ma, mb;
        two  = (op == 3) || (op == 5);
        etag = '0;
        ecnt = 0;
        eerr = (a >= ROWS) || (two && b >= ROWS);
        if (!eerr) begin
            for (int j = 0; j < COLS; j++) begin
                sel = (op >= 4) ? ref_acc[j] : mask[j];
                ma  = (ref_mem[a][j] == key[0]);
                mb  = two ? (ref_mem[b][j] == key[1]) : 1'b1;
                if (sel && ma && mb) begin
                    etag[j] = 1'b1;
                    ecnt++;
                end
            end
            ref_acc = etag;
        end
    endtask

    // Present a command at a negedge and wait (bounded) for the accepting edge.
    task automatic send(input int op, input int a, input int b, input logic [1:0] key,
                        input logic [31:0] data, input logic [31:0] mask);
        int n;
        cmd_op    = 3'(op);
        cmd_row_a = AW'(a);
        cmd_row_b = AW'(b);
        cmd_key   = key;
        cmd_data  = data;
        cmd_mask  = mask;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int op, input int a, input int b, input logic [1:0] key,
                           input logic [31:0] data, input logic [31:0] mask, input int stall);
        logic [31:0] etag;
        int          ecnt;
        logic        eerr;
        logic [31:0] htag;
        logic [CW-1:0] hcnt;
        int          n;
        send(op, a, b, key, data, mask);
        @(negedge CLK);
        check("exec_ready", 64'(cmd_ready), 64'd0);
        check("exec_valid", 64'(rsp_valid), 64'd0);
        if (op >= 2 && op <= 5) begin
            model_search(op, a, b, key, mask, etag, ecnt, eerr);
            @(negedge CLK);
            check("rsp_valid", 64'(rsp_valid), 64'd1);
            check("rsp_tag", 64'(rsp_tag), 64'(etag));
            check("rsp_count", 64'(rsp_count), 64'(ecnt));
            check("rsp_err", 64'(rsp_err), 64'(eerr));
            check("acc_tag", 64'(acc_tag), 64'(ref_acc));
            htag = rsp_tag;
            hcnt = rsp_count;
            for (int s = 0; s < stall; s++) begin
                @(negedge CLK);
                check("stall_valid", 64'(rsp_valid), 64'd1);
                check("stall_tag", 64'(rsp_tag), 64'(htag));
                check("stall_count", 64'(rsp_count), 64'(hcnt));
                check("stall_ready", 64'(cmd_ready), 64'd0);
            end
            rsp_ready = 1'b1;
            @(posedge CLK);
            #1 rsp_ready = 1'b0;
            @(negedge CLK);
            check("rsp_drop", 64'(rsp_valid), 64'd0);
            check("idle_ready", 64'(cmd_ready), 64'd1);
        end else begin
            model_nonsearch(op, a, data, mask);
            @(negedge CLK);
            check("wr_idle_ready", 64'(cmd_ready), 64'd1);
            check("wr_no_rsp", 64'(rsp_valid), 64'd0);
            check("wr_acc", 64'(acc_tag), 64'(ref_acc));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op, a, b;
        // Reset, with a WRITE row0 already presented so it is taken the first free cycle.
        cmd_op    = 3'd0;
        cmd_row_a = '0;
        cmd_data  = 32'hFFFF_0000;
        cmd_valid = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_acc", 64'(acc_tag), 64'hFFFF_FFFF);
        check("rst_tag", 64'(rsp_tag), 64'd0);
        check("rst_count", 64'(rsp_count), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        check("first_accept", 64'(cmd_ready), 64'd0);
        model_nonsearch(0, 0, 32'hFFFF_0000, '0);
        @(negedge CLK);

        // Directed sequence.
        run_cmd(2, 0, 0, 2'b01, '0, 32'hAAAA_AAAA, 0);
        run_cmd(0, 1, 0, 2'b00, 32'h0000_0000, '0, 0);
        run_cmd(1, 1, 0, 2'b00, 32'hFFFF_FFFF, 32'h0000_FFFF, 0);
        run_cmd(3, 0, 1, 2'b01, '0, 32'hFFFF_FFFF, 0);
        run_cmd(7, 0, 0, 2'b00, '0, '0, 0);
        run_cmd(0, 2, 0, 2'b00, 32'h00FF_00FF, '0, 0);
        run_cmd(4, 0, 0, 2'b01, '0, '0, 0);
        run_cmd(4, 2, 0, 2'b01, '0, '0, 0);
        run_cmd(0, 3, 0, 2'b00, 32'h0, '0, 0);
        run_cmd(6, 3, 0, 2'b00, 32'h1234_5678, '0, 0);
        run_cmd(2, 3, 0, 2'b01, '0, 32'hFFFF_FFFF, 5);
        check("row3_merge", 64'(rsp_tag), 64'h0034_0000);
        run_cmd(2, 40, 0, 2'b01, '0, 32'hFFFF_FFFF, 0);
        run_cmd(0, 40, 0, 2'b00, 32'h5A5A_5A5A, '0, 0);
        run_cmd(3, 0, 41, 2'b01, '0, 32'hFFFF_FFFF, 1);

        // Reset during the EXEC cycle of a write to row5.
        run_cmd(0, 5, 0, 2'b00, 32'h0F0F_0F0F, '0, 0);
        send(0, 5, 0, 2'b00, 32'hFFFF_FFFF, '0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        ref_acc = '1;
        check("rstw_valid", 64'(rsp_valid), 64'd0);
        check("rstw_acc", 64'(acc_tag), 64'hFFFF_FFFF);
        check("rstw_ready", 64'(cmd_ready), 64'd1);
        run_cmd(2, 5, 0, 2'b01, '0, 32'hFFFF_FFFF, 0);

        // Reset while a response is pending.
        send(2, 0, 0, 2'b01, '0, 32'hFFFF_FFFF);
        @(negedge CLK);
        @(negedge CLK);
        check("pend_valid", 64'(rsp_valid), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        ref_acc = '1;
        check("rstr_valid", 64'(rsp_valid), 64'd0);
        check("rstr_tag", 64'(rsp_tag), 64'd0);
        check("rstr_acc", 64'(acc_tag), 64'hFFFF_FFFF);

        // Fill every row, then random traffic.
        for (int r = 0; r < ROWS; r++)
            run_cmd(0, r, 0, 2'b00, $urandom, '0, 0);
        for (int i = 0; i < 250; i++) begin
            op = int'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(36, 63)) : int'($urandom_range(0, 35));
            b  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(36, 63)) : int'($urandom_range(0, 35));
            run_cmd(op, a, b, 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
